// File: rtl/mem_access_unit.sv
// Load/store front end: turns CPU byte/half/word requests into aligned word
// accesses on a word-only DMEM. Sub-word stores run as read-modify-write,
// loads are lane-extracted and sign/zero-extended, misaligned requests are
// rejected without touching DMEM.
module mem_access_unit #(
    parameter bit BIG_ENDIAN      = 1'b0,
    parameter bit FAST_WORD_STORE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic        DM_CS,
    output logic        DM_R,
    output logic        DM_W,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state, state_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        sign_ext_q;
    logic [31:0] rbuf;

    logic        req_misalign;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Misalignment is judged on the live request so IDLE can branch to ERR.
    // size 11 is reserved and behaves exactly like a word.
    always_comb begin
        req_misalign = 1'b0;
        if (size == 2'b01)
            req_misalign = addr[0];
        else if (size[1])
            req_misalign = (addr[1:0] != 2'b00);
    end

    // Big-endian mirrors the lane numbering: byte 0 lives in the top lane.
    assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
    assign half_lane = BIG_ENDIAN ? ~addr_q[1]   : addr_q[1];

    // Extract and extend the addressed lane straight from the DMEM read port
    // so rdata is ready in RESP.
    always_comb begin
        load_ext = dm_rdata;
        case (size_q)
            2'b00: begin
                load_ext[7:0]  = dm_rdata[{byte_lane, 3'b000} +: 8];
                load_ext[31:8] = {24{sign_ext_q & load_ext[7]}};
            end
            2'b01: begin
                load_ext[15:0]  = dm_rdata[{half_lane, 4'b0000} +: 16];
                load_ext[31:16] = {16{sign_ext_q & load_ext[15]}};
            end
            default: load_ext = dm_rdata;
        endcase
    end

    // Merge store data into the read-back word; full words bypass rbuf.
    always_comb begin
        merged = rbuf;
        case (size_q)
            2'b00:   merged[{byte_lane, 3'b000} +: 8]   = wdata_q[7:0];
            2'b01:   merged[{half_lane, 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    assign dm_addr  = {addr_q[31:2], 2'b00};
    assign dm_wdata = merged;

    // State register; async reset drops every decoded strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        misalign  = 1'b0;
        DM_CS     = 1'b0;
        DM_R      = 1'b0;
        DM_W      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (req_misalign)
                        state_nxt = ERR;
                    else if (we && size[1] && FAST_WORD_STORE)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                DM_CS     = 1'b1;
                DM_R      = 1'b1;
                state_nxt = we_q ? WR : RESP;
            end
            WR: begin
                DM_CS     = 1'b1;
                DM_W      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                misalign  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture in IDLE; read buffer and load result at the end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
            rbuf       <= '0;
            rdata      <= '0;
        end else begin
            if (state == IDLE && req) begin
                addr_q     <= addr;
                wdata_q    <= wdata;
                size_q     <= size;
                we_q       <= we;
                sign_ext_q <= sign_ext;
            end
            if (state == RD) begin
                rbuf <= dm_rdata;
                if (!we_q) rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word DMEM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misalign;
    logic [31:0] rdata;
    logic        DM_CS, DM_R, DM_W;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .misalign(misalign), .rdata(rdata), .DM_CS(DM_CS),
        .DM_R(DM_R), .DM_W(DM_W), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    // Word-only DMEM: combinational read, write on posedge while DM_W is high.
    assign dm_rdata = mem[dm_addr[11:2]];
    always @(posedge clk)
        if (DM_CS && DM_W) mem[dm_addr[11:2]] <= dm_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access: req in cycle T, returns cycles until done, misalign and
    // strobe counts. hold_req keeps req high with a decoy address while busy.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input bit hold_req,
                          output int lat, output logic mis, output int n_cs,
                          output int n_w, output int n_r);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        lat = 0; n_cs = 0; n_w = 0; n_r = 0; mis = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_req) begin
                addr  = 32'h0000_0300;
                wdata = 32'h5555_5555;
            end else begin
                req = 1'b0;
            end
            lat++;
            if (DM_CS) n_cs++;
            if (DM_W)  n_w++;
            if (DM_R)  n_r++;
            if (done) begin
                mis = misalign;
                req = 1'b0;
                break;
            end
            if (lat > 10) begin
                chk("timeout", 32'(lat), 32'd0);
                req = 1'b0;
                break;
            end
        end
    endtask

    int          lat, ncs, nw, nr;
    logic        mis;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        mem[32'h100 >> 2] = 32'h1122_3344;
        mem[32'h104 >> 2] = 32'h8000_F00D;

        // Reset state
        @(negedge clk);
        chk("rst busy",     {31'd0, busy},  32'd0);
        chk("rst done",     {31'd0, done},  32'd0);
        chk("rst strobes",  {29'd0, DM_CS, DM_R, DM_W}, 32'd0);
        chk("rst rdata",    rdata,    32'd0);
        chk("rst dm_addr",  dm_addr,  32'd0);
        chk("rst dm_wdata", dm_wdata, 32'd0);
        rst_n = 1'b1;

        // lbu 0x103
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("lbu lat",   32'(lat), 32'd2);
        chk("lbu mis",   {31'd0, mis}, 32'd0);
        chk("lbu rdata", rdata, 32'h0000_0011);
        chk("lbu DM_R",  32'(nr), 32'd1);

        // lb 0x100 with sign: 0x44 positive
        access(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("lb pos rdata", rdata, 32'h0000_0044);

        // sb 0x101 0xAB: RMW
        access(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FFAB, 1'b0, lat, mis, ncs, nw, nr);
        chk("sb lat",  32'(lat), 32'd3);
        chk("sb DM_W", 32'(nw), 32'd1);
        chk("sb DM_R", 32'(nr), 32'd1);
        chk("sb mem",  mem[32'h100 >> 2], 32'h1122_AB44);

        // lb 0x101 sign-extended: 0xAB negative
        access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("lb neg rdata", rdata, 32'hFFFF_FFAB);

        // lh / lhu 0x106 on 0x8000F00D
        access(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("lh rdata",  rdata, 32'hFFFF_8000);
        access(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("lhu rdata", rdata, 32'h0000_8000);
        access(1'b0, 2'b01, 1'b1, 32'h104, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("lh low rdata", rdata, 32'hFFFF_F00D);

        // Misaligned lw 0x102: rdata keeps 0xFFFFF00D
        access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("mis lat",   32'(lat), 32'd1);
        chk("mis flag",  {31'd0, mis}, 32'd1);
        chk("mis DM_CS", 32'(ncs), 32'd0);
        chk("mis rdata", rdata, 32'hFFFF_F00D);

        // Misaligned sh 0x103: no write
        access(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000_9999, 1'b0, lat, mis, ncs, nw, nr);
        chk("mis sh flag", {31'd0, mis}, 32'd1);
        chk("mis sh mem",  mem[32'h100 >> 2], 32'h1122_AB44);

        // Fast sw 0x200 with req held high while busy
        access(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b1, lat, mis, ncs, nw, nr);
        chk("sw lat",   32'(lat), 32'd2);
        chk("sw DM_R",  32'(nr), 32'd0);
        chk("sw DM_W",  32'(nw), 32'd1);
        chk("sw mem",   mem[32'h200 >> 2], 32'hDEAD_BEEF);
        chk("sw decoy", mem[32'h300 >> 2], 32'h0);
        @(negedge clk);
        chk("sw idle",  {31'd0, busy}, 32'd0);

        // sh 0x102: reset during WR, no write
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h102; wdata = 32'h1234;
        @(negedge clk); req = 1'b0;   // RD
        @(negedge clk);               // WR
        chk("rstwr in WR", {31'd0, DM_W}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstwr strobes", {28'd0, busy, DM_CS, DM_R, DM_W}, 32'd0);
        chk("rstwr rdata",   rdata,   32'd0);
        chk("rstwr dm_addr", dm_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstwr mem", mem[32'h100 >> 2], 32'h1122_AB44);
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, lat, mis, ncs, nw, nr);
        chk("rstwr lw", rdata, 32'h1122_AB44);

        // sh 0x102 completes normally
        access(1'b1, 2'b01, 1'b0, 32'h102, 32'hCAFE_5678, 1'b0, lat, mis, ncs, nw, nr);
        chk("sh lat", 32'(lat), 32'd3);
        chk("sh mem", mem[32'h100 >> 2], 32'h5678_AB44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
